// File: rtl/trace_pkg.sv
// Shared widths and the retirement record layout for the commit trace buffer.
package trace_pkg;

    localparam int TRACE_PC_W   = 32;
    localparam int TRACE_ADDR_W = 5;
    localparam int TRACE_DATA_W = 32;

    // The sequence number is appended by the top level because its width is a parameter.
    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_ADDR_W-1:0] waddr;
        logic [TRACE_DATA_W-1:0] wdata;
        logic                    wen;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Register-based FIFO with occupancy count and synchronous clear; DEPTH must be a power of two.
module trace_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never observable while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures one normalised retirement record per commit and streams them out in order;
// the processor never stalls, so a full buffer drops records and leaves a sequence gap.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int SEQ_W  = 16,
    parameter  int DROP_W = 8,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    commit_val,
    input  logic [TRACE_PC_W-1:0]   commit_pc,
    input  logic [TRACE_ADDR_W-1:0] commit_waddr,
    input  logic [TRACE_DATA_W-1:0] commit_wdata,
    input  logic                    commit_wen,
    output logic                    trace_val,
    input  logic                    trace_rdy,
    output logic [TRACE_PC_W-1:0]   trace_pc,
    output logic [TRACE_ADDR_W-1:0] trace_waddr,
    output logic [TRACE_DATA_W-1:0] trace_wdata,
    output logic                    trace_wen,
    output logic [SEQ_W-1:0]        trace_seq,
    output logic [CW-1:0]           count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int REC_W = $bits(trace_rec_t);
    localparam int ENT_W = REC_W + SEQ_W;

    trace_rec_t        cap_rec;
    trace_rec_t        head_rec;
    logic              cap_wen;
    logic [ENT_W-1:0]  fifo_wdata;
    logic [ENT_W-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    // Writes to x0 are architecturally invisible, and a non-writing record carries no payload.
    assign cap_wen = commit_wen && (commit_waddr != '0);

    always_comb begin
        cap_rec       = '0;
        cap_rec.pc    = commit_pc;
        cap_rec.wen   = cap_wen;
        cap_rec.waddr = cap_wen ? commit_waddr : '0;
        cap_rec.wdata = cap_wen ? commit_wdata : '0;
    end

    assign fifo_wdata = {seq_q, cap_rec};
    assign pop        = !fifo_empty && trace_rdy && !clear;
    assign push       = commit_val && !clear && (!fifo_full || pop);
    assign drop       = commit_val && !clear && !push;

    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (commit_val) seq_d = seq_q + SEQ_W'(1);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    trace_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign head_rec = fifo_rdata[REC_W-1:0];

    always_comb begin
        trace_val   = !fifo_empty;
        trace_pc    = '0;
        trace_waddr = '0;
        trace_wdata = '0;
        trace_wen   = 1'b0;
        trace_seq   = '0;
        if (!fifo_empty) begin
            trace_pc    = head_rec.pc;
            trace_waddr = head_rec.waddr;
            trace_wdata = head_rec.wdata;
            trace_wen   = head_rec.wen;
            trace_seq   = fifo_rdata[ENT_W-1 -: SEQ_W];
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits at the commit stage of the RTL processor and captures one retirement record per committed instruction: pc, register write address, write data and write enable.
- Buffers records in a small FIFO and presents them, in order, on a val/rdy stream to a trace consumer (test-bench checker or debug port).
- The processor never stalls for this block. Overflow drops the record, sets a sticky flag and leaves a sequence-number gap the consumer can detect.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- SEQ_W, 16, width of the per-commit sequence number.
- DROP_W, 8, width of the saturating dropped-record counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (rst=0 resets).
- clear  in  1  synchronous flush.
- commit_val  in  1  an instruction commits this cycle.
- commit_pc  in  32  pc of the committing instruction.
- commit_waddr  in  5  destination register.
- commit_wdata  in  32  writeback data.
- commit_wen  in  1  register write occurs.
- trace_val  out  1  head record valid.
- trace_rdy  in  1  consumer accepts head.
- trace_pc  out  32  head pc.
- trace_waddr  out  5  head waddr.
- trace_wdata  out  32  head wdata.
- trace_wen  out  1  head wen.
- trace_seq  out  SEQ_W  head sequence number.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: at least one record dropped.
- drop_count  out  DROP_W  dropped records, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Read/write pointers, count, seq counter, overflow and drop_count all go to 0.
  - trace_val=0 and all trace_* data outputs are 0.
- Normalisation at capture:
  - If commit_wen=1 and commit_waddr=0, the stored wen is 0 (x0 writes are invisible).
  - Whenever the stored wen=0, the stored waddr and wdata are 0.
- Sequence counter:
  - Increments by 1 on every cycle with commit_val=1 and clear=0, whether the record is stored or dropped.
  - The stored seq is the counter value before the increment, so the first commit after reset has seq 0.
  - Wraps modulo 2^SEQ_W.
- Enqueue:
  - Accepted when commit_val=1, clear=0, and either count<DEPTH or a dequeue fires in the same cycle (full with simultaneous pop is accepted).
  - Otherwise the record is dropped: overflow is set (sticky) and drop_count increments, saturating at all-ones.
- Dequeue:
  - Fires when trace_val and trace_rdy are both 1; the head advances next cycle.
  - trace_val=1 exactly when count>0.
  - trace_* outputs show the head entry and are driven to 0 when empty.
- Latency:
  - A record captured in cycle N is visible on trace_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- count: increments on push-only, decrements on pop-only.
- clear=1:
  - Next cycle the FIFO is empty (trace_val=0) and count, seq counter, overflow and drop_count are all 0.
  - A commit in the same cycle is discarded and not counted.
  - A pop in the same cycle is ignored.
- Priority: rst > clear > push/pop.
- trace_rdy with trace_val=0 has no effect.
- Reset mid-stream: all buffered records are lost and the state equals the post-reset state above.

Decomposition:
- Package trace_pkg holds:
  - TRACE_PC_W=32, TRACE_ADDR_W=5, TRACE_DATA_W=32.
  - A packed struct trace_rec_t {pc, waddr, wdata, wen}. The seq field is appended in the module because its width is a parameter.
- Sub-module trace_fifo: generic DEPTH-entry register-based FIFO with push, pop, full, empty, count and a synchronous clear.
  - The top module contains the normalisation, seq counter, drop/overflow logic and output zeroing.

Test Plan:
- Basic capture:
  - Stimulus: after reset, commit pc=0x200, waddr=5, wdata=0x2A, wen=1, with trace_rdy=1.
  - Required: next cycle trace_val=1 with pc=0x200, waddr=5, wdata=0x2A, wen=1, seq=0. The following cycle trace_val=0 and count=0.
- x0 normalisation:
  - Stimulus: commit pc=0x204, waddr=0, wdata=0xDEADBEEF, wen=1.
  - Required: trace_wen=0, trace_waddr=0, trace_wdata=0.
- Back-pressure and overflow (DEPTH=8):
  - Stimulus: trace_rdy=0 while 10 consecutive commits arrive at pc=0x200+4k.
  - Required: count=8, overflow=1, drop_count=2. Draining yields seq 0..7, pc 0x200..0x21C.
  - Then: the next commit gets seq 10, a visible gap.
- Full with simultaneous pop:
  - Stimulus: FIFO full, trace_rdy=1 and commit_val=1 in the same cycle.
  - Required: no drop, count stays 8, overflow unchanged.
- Clear:
  - Stimulus: 3 entries buffered, overflow=1, then clear=1 together with commit_val=1.
  - Required: next cycle trace_val=0, count=0, overflow=0, drop_count=0. The next commit gets seq 0.
- Async reset mid-stream:
  - Stimulus: rst=0 asserted between clock edges with 4 entries buffered.
  - Required: trace_val=0, count=0 and all outputs 0 immediately, before the next edge.
